mult_div_unit: RTL

Iterative signed multiply/divide unit for the multicycle CPU datapath, sitting directly downstream of the control unit. It consumes the A/B operand registers, the `Div_Mult_Ctrl` operation select, a start strobe and the HI/LO `write` enable. It produces the architectural HI and LO registers plus the `DIV0` exception flag, which the control unit samples. Both MULT and DIV complete in fixed latency using 32 magnitude shift iterations followed by one sign-correction cycle.

---
 rtl/mult_div_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit: 32 magnitude shift iterations followed by
// one sign-correction cycle, with architectural HI/LO registers and a sticky DIV0 flag.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic             Div_Mult_Ctrl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             write,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             DIV0
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH, S_DONE} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic               op_div, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_op;       // |a| addend for MULT, |b| divisor for DIV
    logic [2*WIDTH:0]   acc;          // {upper W+1 bits, lower W bits}
    logic [WIDTH-1:0]   res_hi, res_lo;

    logic               div_by_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH:0]   mul_next, div_next;
    logic [WIDTH:0]     mul_upper, rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign mag_a       = a_in[WIDTH-1] ? -a_in : a_in;
    assign mag_b       = b_in[WIDTH-1] ? -b_in : b_in;
    assign div_by_zero = Div_Mult_Ctrl && (b_in == '0);

    // State register
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) state <= S_IDLE;
        else           state <= state_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaulting every always_comb output first keeps a missed branch from inferring a latch.
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = div_by_zero ? S_DONE : S_RUN;
            S_RUN:    if (count == CNT_LAST) state_next = S_FINISH;
            S_FINISH: state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == S_RUN) || (state == S_FINISH);
        done = (state == S_DONE);
    end

    // One iteration of shift-add (LSB first) and restoring division (MSB first)
    always_comb begin
        mul_upper = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_op} : '0);
        mul_next  = {mul_upper, acc[WIDTH-1:0]} >> 1;
        rem_sh    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = {1'b0, rem_sh} - {2'b00, mag_op};
        if (!diff[WIDTH+1]) div_next = {diff[WIDTH:0], acc[WIDTH-2:0], 1'b1};
        else                div_next = {rem_sh, acc[WIDTH-2:0], 1'b0};
    end

    // Sign correction: remainder follows the dividend, so division truncates toward zero
    always_comb begin
        prod_s = (sign_a ^ sign_b) ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        quo_s  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_s  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            count  <= '0;
            op_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_op <= '0;
            acc    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            DIV0   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            // NOTE: non-blocking updates let a write on the FINISH edge load the old res_hi/res_lo.
            if (write) begin
                HI <= res_hi;
                LO <= res_lo;
            end
            case (state)
                S_IDLE: if (start) begin
                    if (div_by_zero) begin
                        DIV0 <= 1'b1;
                    end else begin
                        DIV0   <= 1'b0;
                        count  <= '0;
                        op_div <= Div_Mult_Ctrl;
                        sign_a <= a_in[WIDTH-1];
                        sign_b <= b_in[WIDTH-1];
                        mag_op <= Div_Mult_Ctrl ? mag_b : mag_a;
                        acc    <= {{(WIDTH+1){1'b0}}, Div_Mult_Ctrl ? mag_a : mag_b};
                    end
                end
                S_RUN: begin
                    acc   <= op_div ? div_next : mul_next;
                    count <= count + CNT_ONE;
                end
                S_FINISH: begin
                    if (op_div) begin
                        res_hi <= rem_s;
                        res_lo <= quo_s;
                    end else begin
                        res_hi <= prod_s[2*WIDTH-1:WIDTH];
                        res_lo <= prod_s[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
